multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//   Multi-cycle sequencer for the RV32 core: fetches an instruction, latches it in
//   the instruction register (IR) that drives Immediate_Generation, and steps the
//   datapath through FETCH/DECODE/EXEC/MEM/WB. Supported: ADDI, AUIPC, LW, SW,
//   ADD/SUB. Any other encoding traps. Also counts retired instructions.
// PARAMETERS
//   DATA_WIDTH  32             instruction / datapath width
//   RESET_IR    32'h00000013   IR value after reset (addi x0,x0,0)
// PORTS
//   clk          in   1           clock, all state updates on rising edge
//   rst          in   1           synchronous active-high reset
//   imem_valid   in   1           instr_rdata valid this cycle
//   instr_rdata  in   DATA_WIDTH  fetched instruction word
//   dmem_ready   in   1           data memory accepts/completes access this cycle
//   imem_req     out  1           instruction fetch request
//   ir           out  DATA_WIDTH  instruction register (feeds imm gen, regfile addrs)
//   pc_write     out  1           PC <= PC+4 this cycle
//   alu_a_sel    out  1           0: rs1, 1: PC
//   alu_b_sel    out  1           0: rs2, 1: immediate
//   alu_sub      out  1           ALU subtracts (SUB only), else add
//   dmem_req     out  1           data memory request
//   dmem_we      out  1           data memory write (SW)
//   wb_sel       out  1           0: ALU result, 1: load data
//   reg_write    out  1           register file write enable
//   illegal      out  1           sticky trap flag
//   state        out  3           FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   instret      out  32          retired-instruction counter
// BEHAVIOUR
//   Reset (rst=1 at edge): state=FETCH, ir=RESET_IR, instret=0, illegal=0; rst
//     wins over every other event, including mid-MEM (access abandoned, no retire).
//   Outputs are decoded from state+ir; unlisted outputs are 0 in each state.
//   FETCH: imem_req=1. imem_valid=1 -> ir<=instr_rdata, ->DECODE; else hold.
//   DECODE (1 cycle): legal = opcode 0010011 (f3=000), 0010111, 0000011 (f3=010),
//     0100011 (f3=010), 0110011 (f3=000, f7=0000000 or 0100000). legal->EXEC,
//     else ->TRAP.
//   EXEC (1 cycle): ADDI/LW/SW: a=rs1,b=imm; AUIPC: a=PC,b=imm; R: a=rs1,b=rs2,
//     alu_sub=ir[30]. LW/SW->MEM, others->WB. Selects held stable into MEM/WB.
//   MEM: dmem_req=1, dmem_we=1 for SW; hold until dmem_ready. On ready: SW ->
//     pc_write=1, instret++, ->FETCH (same cycle); LW -> WB.
//   WB (1 cycle): reg_write=1 unless ir[11:7]==0; wb_sel=1 for LW; pc_write=1;
//     instret++; ->FETCH.
//   TRAP: illegal=1, no requests, no writes; absorbing until rst.
//   imem_valid outside FETCH and dmem_ready outside MEM are ignored.
//   instret wraps 32'hFFFFFFFF -> 0. Exactly one pc_write per retired instr.
//   Best-case latency: ADDI/AUIPC/ADD/SW 4 cycles, LW 5 cycles.
// TESTING
//   1 rst=1 two cycles mid-MEM of SW -> next cycle state=0, ir=0x13, instret=0,
//     imem_req=1, dmem_req=0, no pc_write seen.
//   2 ADDI 0x00500093, imem_valid at once -> states 0,1,2,4; WB: reg_write=1,
//     alu_b_sel=1, pc_write=1; instret 0->1.
//   3 SW 0x0020A223, dmem_ready low 3 cycles -> dmem_req=dmem_we=1 for 4 cycles,
//     pc_write only in ready cycle, then FETCH; reg_write never 1.
//   4 LW 0x0000A103 then SUB 0x40208033 -> LW WB wb_sel=1; SUB EXEC alu_sub=1,
//     alu_a/b_sel=0; instret=2 after both.
//   5 ADDI x0 0x00100013 -> WB reg_write=0, pc_write=1; instret increments.
//   6 0xFFFFFFFF fetched -> DECODE->TRAP, illegal=1 held 10 cycles, imem_req=0;
//     rst -> illegal=0, state=0. Also preload instret=0xFFFFFFFF -> retire wraps 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multi-cycle sequencer for the RV32 core. Fetches an instruction, latches it
//   into the instruction register (IR) and steps the datapath through
//   FETCH/DECODE/EXEC/MEM/WB. Supports ADDI, AUIPC, LW, SW and ADD/SUB; any other
//   encoding enters an absorbing TRAP state. Counts retired instructions.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   imem_valid      instr_rdata valid this cycle (only observed in FETCH)
//   instr_rdata     fetched instruction word
//   dmem_ready      data memory completes the access this cycle (only observed in MEM)
//   imem_req        instruction fetch request
//   ir              instruction register
//   pc_write        PC <= PC+4 this cycle (one per retired instruction)
//   alu_a_sel       0: rs1, 1: PC
//   alu_b_sel       0: rs2, 1: immediate
//   alu_sub         ALU subtracts (SUB only)
//   dmem_req        data memory request
//   dmem_we         data memory write (SW)
//   wb_sel          0: ALU result, 1: load data
//   reg_write       register file write enable
//   illegal         trap flag, held until reset
//   state           FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   instret         retired-instruction counter (wraps)
module multicycle_control_fsm #(
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_IR   = DATA_WIDTH'(32'h00000013)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_valid,
   input  logic [DATA_WIDTH-1:0] instr_rdata,
   input  logic                  dmem_ready,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] ir,
   output logic                  pc_write,
   output logic                  alu_a_sel,
   output logic                  alu_b_sel,
   output logic                  alu_sub,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic                  wb_sel,
   output logic                  reg_write,
   output logic                  illegal,
   output logic [2:0]            state,
   output logic [31:0]           instret
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd7
   } state_e;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   ir_q, ir_d;
   logic [31:0]             instret_q, instret_d;

   // Instruction fields
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];
   assign rd     = ir_q[11:7];

   logic is_addi, is_auipc, is_lw, is_sw, is_r, legal;

   assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign is_auipc = (opcode == 7'b0010111);
   assign is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
   assign is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
   assign is_r     = (opcode == 7'b0110011) && (funct3 == 3'b000) &&
                     ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
   assign legal    = is_addi | is_auipc | is_lw | is_sw | is_r;

   // Next state and decoded outputs
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      imem_req  = 1'b0;
      pc_write  = 1'b0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_sub   = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      wb_sel    = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;

      case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               ir_d    = instr_rdata;
               state_d = StDecode;
            end
         end
         StDecode: begin
            state_d = legal ? StExec : StTrap;
         end
         StExec: begin
            alu_a_sel = is_auipc;
            alu_b_sel = ~is_r;
            alu_sub   = is_r & ir_q[30];
            state_d   = (is_lw || is_sw) ? StMem : StWb;
         end
         StMem: begin
            // ALU selects stay put so the address remains stable
            alu_a_sel = is_auipc;
            alu_b_sel = ~is_r;
            alu_sub   = is_r & ir_q[30];
            dmem_req  = 1'b1;
            dmem_we   = is_sw;
            if (dmem_ready) begin
               if (is_sw) begin
                  pc_write = 1'b1;
                  state_d  = StFetch;
               end else begin
                  state_d  = StWb;
               end
            end
         end
         StWb: begin
            alu_a_sel = is_auipc;
            alu_b_sel = ~is_r;
            alu_sub   = is_r & ir_q[30];
            wb_sel    = is_lw;
            reg_write = (rd != 5'd0);
            pc_write  = 1'b1;
            state_d   = StFetch;
         end
         StTrap: begin
            illegal = 1'b1;
         end
         default: begin
            state_d = StTrap;
         end
      endcase

      // Reset abandons any in-flight access: no architectural write may escape
      if (rst) begin
         pc_write  = 1'b0;
         reg_write = 1'b0;
      end

      instret_d = pc_write ? (instret_q + 32'd1) : instret_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFetch;
         ir_q      <= RESET_IR;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
      end
   end

   assign ir      = ir_q;
   assign state   = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. The stimulus process drives one
// cycle at a time and pushes the hand-computed expected outputs for that cycle
// into a queue; a monitor pops and compares on every falling edge.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_valid;
   logic [31:0] instr_rdata;
   logic        dmem_ready;
   logic        imem_req, pc_write, alu_a_sel, alu_b_sel, alu_sub;
   logic        dmem_req, dmem_we, wb_sel, reg_write, illegal;
   logic [31:0] ir;
   logic [2:0]  state;
   logic [31:0] instret;

   multicycle_control_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .imem_valid  (imem_valid),
      .instr_rdata (instr_rdata),
      .dmem_ready  (dmem_ready),
      .imem_req    (imem_req),
      .ir          (ir),
      .pc_write    (pc_write),
      .alu_a_sel   (alu_a_sel),
      .alu_b_sel   (alu_b_sel),
      .alu_sub     (alu_sub),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .wb_sel      (wb_sel),
      .reg_write   (reg_write),
      .illegal     (illegal),
      .state       (state),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] ADDI0 = 32'h00100013;
   localparam logic [31:0] AUIPC = 32'h00000097;
   localparam logic [31:0] SW    = 32'h0020A223;
   localparam logic [31:0] LW    = 32'h0000A103;
   localparam logic [31:0] SUB   = 32'h40208033;
   localparam logic [31:0] BAD   = 32'hFFFFFFFF;

   // ctl bits: {imem_req,pc_write,a_sel,b_sel,sub,dmem_req,dmem_we,wb_sel,reg_write,illegal}
   localparam logic [9:0] C_FETCH    = 10'b1000000000;
   localparam logic [9:0] C_NONE     = 10'b0000000000;
   localparam logic [9:0] C_EX_I     = 10'b0001000000;
   localparam logic [9:0] C_EX_AUI   = 10'b0011000000;
   localparam logic [9:0] C_WB_AUI   = 10'b0111000010;
   localparam logic [9:0] C_WB_ADDI  = 10'b0101000010;
   localparam logic [9:0] C_WB_ADDI0 = 10'b0101000000;
   localparam logic [9:0] C_MEM_SW   = 10'b0001011000;
   localparam logic [9:0] C_MEM_SWR  = 10'b0101011000;
   localparam logic [9:0] C_MEM_LW   = 10'b0001010000;
   localparam logic [9:0] C_WB_LW    = 10'b0101000110;
   localparam logic [9:0] C_EX_SUB   = 10'b0000100000;
   localparam logic [9:0] C_WB_SUB   = 10'b0100100000;
   localparam logic [9:0] C_TRAP     = 10'b0000000001;

   typedef struct {
      string       nm;
      logic [2:0]  st;
      logic [9:0]  ctl;
      logic [31:0] ir;
      logic [31:0] ins;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Drive one cycle of inputs and queue the outputs expected during that cycle
   task automatic cyc(input logic r, input logic iv, input logic [31:0] rd, input logic dr,
                      input string nm, input logic [2:0] st, input logic [9:0] ctl,
                      input logic [31:0] eir, input logic [31:0] eins);
      exp_t e;
      rst         = r;
      imem_valid  = iv;
      instr_rdata = rd;
      dmem_ready  = dr;
      e.nm  = nm;
      e.st  = st;
      e.ctl = ctl;
      e.ir  = eir;
      e.ins = eins;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor
   initial begin
      exp_t        e;
      logic [9:0]  act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {imem_req, pc_write, alu_a_sel, alu_b_sel, alu_sub,
                   dmem_req, dmem_we, wb_sel, reg_write, illegal};
            total++;
            if (state !== e.st || act !== e.ctl || ir !== e.ir || instret !== e.ins) begin
               bad++;
               $display("FAIL %s: got st=%0d ctl=%b ir=%h instret=%h, want st=%0d ctl=%b ir=%h instret=%h",
                        e.nm, state, act, ir, instret, e.st, e.ctl, e.ir, e.ins);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; imem_valid = 1'b0; instr_rdata = 32'h0; dmem_ready = 1'b0;
      @(posedge clk);
      #1;

      // ADDI x1: 0,1,2,4; stray imem_valid/dmem_ready in DECODE are ignored
      cyc(0, 1, ADDI, 0, "addi_fetch",  0, C_FETCH,   NOP,  0);
      cyc(0, 1, SW,   1, "addi_decode", 1, C_NONE,    ADDI, 0);
      cyc(0, 0, 0,    1, "addi_exec",   2, C_EX_I,    ADDI, 0);
      cyc(0, 0, 0,    0, "addi_wb",     4, C_WB_ADDI, ADDI, 0);

      // ADDI x0: no register write, still retires
      cyc(0, 1, ADDI0, 0, "addi0_fetch",  0, C_FETCH,    ADDI,  1);
      cyc(0, 0, 0,     0, "addi0_decode", 1, C_NONE,     ADDI0, 1);
      cyc(0, 0, 0,     0, "addi0_exec",   2, C_EX_I,     ADDI0, 1);
      cyc(0, 0, 0,     0, "addi0_wb",     4, C_WB_ADDI0, ADDI0, 1);

      // AUIPC x1
      cyc(0, 1, AUIPC, 0, "auipc_fetch",  0, C_FETCH,  ADDI0, 2);
      cyc(0, 0, 0,     0, "auipc_decode", 1, C_NONE,   AUIPC, 2);
      cyc(0, 0, 0,     0, "auipc_exec",   2, C_EX_AUI, AUIPC, 2);
      cyc(0, 0, 0,     0, "auipc_wb",     4, C_WB_AUI, AUIPC, 2);

      // SW with a fetch stall and three wait cycles in MEM
      cyc(0, 0, SW, 0, "sw_fetch_wait", 0, C_FETCH,   AUIPC, 3);
      cyc(0, 1, SW, 0, "sw_fetch",      0, C_FETCH,   AUIPC, 3);
      cyc(0, 0, 0,  0, "sw_decode",     1, C_NONE,    SW,    3);
      cyc(0, 0, 0,  0, "sw_exec",       2, C_EX_I,    SW,    3);
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 0, "sw_mem_wait", 3, C_MEM_SW,  SW,    3);
      cyc(0, 0, 0,  1, "sw_mem_ready",  3, C_MEM_SWR, SW,    3);

      // LW x2 then SUB x0
      cyc(0, 1, LW,  0, "lw_fetch",   0, C_FETCH,  SW,  4);
      cyc(0, 0, 0,   0, "lw_decode",  1, C_NONE,   LW,  4);
      cyc(0, 0, 0,   0, "lw_exec",    2, C_EX_I,   LW,  4);
      cyc(0, 0, 0,   1, "lw_mem",     3, C_MEM_LW, LW,  4);
      cyc(0, 0, 0,   0, "lw_wb",      4, C_WB_LW,  LW,  4);
      cyc(0, 1, SUB, 0, "sub_fetch",  0, C_FETCH,  LW,  5);
      cyc(0, 0, 0,   0, "sub_decode", 1, C_NONE,   SUB, 5);
      cyc(0, 0, 0,   0, "sub_exec",   2, C_EX_SUB, SUB, 5);
      cyc(0, 0, 0,   0, "sub_wb",     4, C_WB_SUB, SUB, 5);

      // Reset for two cycles while SW sits in MEM with dmem_ready high
      cyc(0, 1, SW, 0, "rst_sw_fetch",  0, C_FETCH,  SUB, 6);
      cyc(0, 0, 0,  0, "rst_sw_decode", 1, C_NONE,   SW,  6);
      cyc(0, 0, 0,  0, "rst_sw_exec",   2, C_EX_I,   SW,  6);
      cyc(0, 0, 0,  0, "rst_sw_mem",    3, C_MEM_SW, SW,  6);
      cyc(1, 0, 0,  1, "rst_in_mem",    3, C_MEM_SW, SW,  6);
      cyc(1, 0, 0,  1, "rst_second",    0, C_FETCH,  NOP, 0);

      // Preload instret to all-ones, then retire one ADDI to wrap it
      force dut.instret_q = 32'hFFFFFFFF;
      cyc(0, 0, 0, 0, "preload", 0, C_FETCH, NOP, 32'hFFFFFFFF);
      release dut.instret_q;
      cyc(0, 1, ADDI, 0, "wrap_fetch",  0, C_FETCH,   NOP,  32'hFFFFFFFF);
      cyc(0, 0, 0,    0, "wrap_decode", 1, C_NONE,    ADDI, 32'hFFFFFFFF);
      cyc(0, 0, 0,    0, "wrap_exec",   2, C_EX_I,    ADDI, 32'hFFFFFFFF);
      cyc(0, 0, 0,    0, "wrap_wb",     4, C_WB_ADDI, ADDI, 32'hFFFFFFFF);

      // Illegal encoding traps and stays there until reset
      cyc(0, 1, BAD, 0, "bad_fetch",  0, C_FETCH, ADDI, 0);
      cyc(0, 0, 0,   0, "bad_decode", 1, C_NONE,  BAD,  0);
      for (int i = 0; i < 10; i++)
         cyc(0, 1, NOP, 1, "trap_hold", 7, C_TRAP, BAD, 0);
      cyc(1, 0, 0, 0, "trap_rst",   7, C_TRAP,  BAD, 0);
      cyc(0, 0, 0, 0, "after_trap", 0, C_FETCH, NOP, 0);

      // Let the monitor drain the queue, bounded
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
